// File: rtl/fifo_flux.sv
// fifo_flux: tagged multi-flux token FIFO.
// One circular queue per flux shares a single write port and a single
// first-word-fall-through read port. Fluxes never block each other: a full
// flux only drops its own tokens and raises its own sticky overflow flag.
module fifo_flux #(
  parameter int DATA_WIDTH = 4,
  parameter int DEPTH      = 4,
  parameter int FLUX       = 1,
  localparam int TAG_W     = (FLUX > 1) ? $clog2(FLUX) : 0,
  localparam int TW        = DATA_WIDTH + TAG_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [TW-1:0]   din,
  input  logic            write,
  output logic [FLUX-1:0] full,
  output logic [TW-1:0]   dout,
  input  logic [FLUX-1:0] read,
  output logic [FLUX-1:0] empty,
  output logic [FLUX-1:0] overflow
);

  // Flux index width is at least one bit so the selects stay legal when FLUX = 1.
  localparam int SEL_W = (FLUX > 1) ? $clog2(FLUX) : 1;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  // Storage and per-flux bookkeeping.
  logic [DATA_WIDTH-1:0] mem_r   [FLUX][DEPTH];
  logic [PTR_W-1:0]      wptr_r  [FLUX];
  logic [PTR_W-1:0]      rptr_r  [FLUX];
  logic [CNT_W-1:0]      count_r [FLUX];
  logic [FLUX-1:0]       overflow_r;

  // Decoded write request.
  logic [SEL_W-1:0]      wr_flux_s;
  logic                  wr_tag_ok_s;
  logic [DATA_WIDTH-1:0] wr_data_s;

  // Per-flux status and strobes.
  logic [FLUX-1:0]       full_s;
  logic [FLUX-1:0]       empty_s;
  logic [FLUX-1:0]       wr_ok_s;
  logic [FLUX-1:0]       wr_drop_s;
  logic [FLUX-1:0]       rd_ok_s;

  // Read select and output mux.
  logic [SEL_W-1:0]      rd_sel_s;
  logic                  rd_valid_s;
  logic [SEL_W-1:0]      out_sel_s;
  logic                  out_valid_s;
  logic [DATA_WIDTH-1:0] out_data_s;

  // Circular pointer advance by explicit compare, so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    logic [PTR_W-1:0] n;
    if (p == PTR_LAST) begin
      n = '0;
    end else begin
      n = p + PTR_W'(1);
    end
    return n;
  endfunction

  assign wr_data_s = din[DATA_WIDTH-1:0];

  // Tag field decode; a single-flux FIFO has no tag and always targets flux 0.
  generate
    if (FLUX > 1) begin : g_tag
      logic [TAG_W-1:0] tag_s;
      assign tag_s       = din[TW-1:DATA_WIDTH];
      assign wr_flux_s   = tag_s;
      // Tags beyond the last flux are silently discarded.
      assign wr_tag_ok_s = ({1'b0, tag_s} < (TAG_W + 1)'(FLUX));
    end else begin : g_notag
      assign wr_flux_s   = 1'b0;
      assign wr_tag_ok_s = 1'b1;
    end
  endgenerate

  // Full/empty are pure decodes of the registered counts, so they cannot glitch on inputs.
  always_comb begin
    full_s  = '0;
    empty_s = '0;
    for (int f = 0; f < FLUX; f++) begin
      full_s[f]  = (count_r[f] == CNT_FULL);
      empty_s[f] = (count_r[f] == CNT_ZERO);
    end
  end

  // Route the write to its flux; a full flux drops it (a same-cycle read does not make room).
  always_comb begin
    wr_ok_s   = '0;
    wr_drop_s = '0;
    for (int f = 0; f < FLUX; f++) begin
      if (write && wr_tag_ok_s && (wr_flux_s == SEL_W'(f))) begin
        if (full_s[f]) begin
          wr_drop_s[f] = 1'b1;
          wr_ok_s[f]   = 1'b0;
        end else begin
          wr_drop_s[f] = 1'b0;
          wr_ok_s[f]   = 1'b1;
        end
      end else begin
        wr_drop_s[f] = 1'b0;
        wr_ok_s[f]   = 1'b0;
      end
    end
  end

  // Lowest requested non-empty flux wins the read port; other requests are not remembered.
  always_comb begin
    rd_valid_s = 1'b0;
    rd_sel_s   = '0;
    for (int f = 0; f < FLUX; f++) begin
      if (!rd_valid_s && read[f] && !empty_s[f]) begin
        rd_valid_s = 1'b1;
        rd_sel_s   = SEL_W'(f);
      end else begin
        rd_sel_s   = rd_sel_s;
      end
    end
  end

  // One-hot pop strobe for the selected flux.
  always_comb begin
    rd_ok_s = '0;
    for (int f = 0; f < FLUX; f++) begin
      if (rd_valid_s && (rd_sel_s == SEL_W'(f))) begin
        rd_ok_s[f] = 1'b1;
      end else begin
        rd_ok_s[f] = 1'b0;
      end
    end
  end

  // Output source: the flux being read, else the lowest non-empty flux, else nothing.
  always_comb begin
    out_valid_s = 1'b0;
    out_sel_s   = '0;
    if (rd_valid_s) begin
      out_valid_s = 1'b1;
      out_sel_s   = rd_sel_s;
    end else begin
      for (int f = 0; f < FLUX; f++) begin
        if (!out_valid_s && !empty_s[f]) begin
          out_valid_s = 1'b1;
          out_sel_s   = SEL_W'(f);
        end else begin
          out_sel_s   = out_sel_s;
        end
      end
    end
  end

  assign out_data_s = mem_r[out_sel_s][rptr_r[out_sel_s]];

  // Pack the head token; the tag field carries the flux index it came from.
  generate
    if (FLUX > 1) begin : g_dout_tag
      // Tagged output word, zero when every flux is empty.
      always_comb begin
        if (out_valid_s) begin
          dout = {out_sel_s, out_data_s};
        end else begin
          dout = '0;
        end
      end
    end else begin : g_dout_notag
      // Untagged output word, zero when the queue is empty.
      always_comb begin
        if (out_valid_s) begin
          dout = out_data_s;
        end else begin
          dout = '0;
        end
      end
    end
  endgenerate

  // Pointers, counts and sticky overflow; rst clears them immediately without a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int f = 0; f < FLUX; f++) begin
        wptr_r[f]  <= '0;
        rptr_r[f]  <= '0;
        count_r[f] <= '0;
      end
      overflow_r <= '0;
    end else begin
      for (int f = 0; f < FLUX; f++) begin
        if (wr_ok_s[f]) begin
          wptr_r[f] <= ptr_inc(wptr_r[f]);
        end
        if (rd_ok_s[f]) begin
          rptr_r[f] <= ptr_inc(rptr_r[f]);
        end
        case ({wr_ok_s[f], rd_ok_s[f]})
          2'b10:   count_r[f] <= count_r[f] + CNT_W'(1);
          2'b01:   count_r[f] <= count_r[f] - CNT_W'(1);
          default: count_r[f] <= count_r[f];
        endcase
        if (wr_drop_s[f]) begin
          overflow_r[f] <= 1'b1;
        end
      end
    end
  end

  // Token storage has no reset; writes are suppressed while rst is high.
  always_ff @(posedge clk) begin
    for (int f = 0; f < FLUX; f++) begin
      if (!rst && wr_ok_s[f]) begin
        mem_r[f][wptr_r[f]] <= wr_data_s;
      end
    end
  end

  assign full     = full_s;
  assign empty    = empty_s;
  assign overflow = overflow_r;

endmodule
